// File: rtl/iiitb_r2_4bit_bm_if.sv
// Operand/result bundle for the radix-2 Booth multiplier.
//   load : start pulse, sampled on the rising clock edge
//   M, Q : 4-bit signed multiplicand / multiplier
//   P    : 8-bit signed registered product
//   done : product-valid flag
// The master modport is the side that launches multiplications (pads/bench).
// The slave modport is the multiplier itself.
interface iiitb_r2_4bit_bm_if;
  logic       load;
  logic [3:0] M;
  logic [3:0] Q;
  logic [7:0] P;
  logic       done;

  modport master (
    output load,
    output M,
    output Q,
    input  P,
    input  done
  );

  modport slave (
    input  load,
    input  M,
    input  Q,
    output P,
    output done
  );
endinterface

// File: rtl/iiitb_r2_4bit_bm.sv
// Sequential radix-2 Booth multiplier, 4x4 signed -> 8-bit signed product.
// Ports:
//   clock   : system clock, rising edge active
//   reset_n : asynchronous active-low reset
//   bus     : iiitb_r2_4bit_bm_if.slave (load, M, Q in; P, done out)
// A load edge captures the operands; four Booth step edges follow, and the
// fourth one registers P and raises done. load always wins, so asserting it
// mid-run restarts with the new operands while P keeps its last value.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no multiplication in progress; P/done hold
// RUN   | Booth iteration active, one step per clock, cnt counts down
module iiitb_r2_4bit_bm (
  input  logic                 clock,
  input  logic                 reset_n,
  iiitb_r2_4bit_bm_if.slave    bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] a_q, a_d;
  logic [4:0] mr_q, mr_d;
  logic [3:0] qr_q, qr_d;
  logic       q1_q, q1_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] p_q, p_d;
  logic       done_q, done_d;

  logic [4:0] a_sum;
  logic [4:0] a_sh;
  logic [3:0] qr_sh;
  logic       q1_sh;
  logic       last_step;

  // Booth add/subtract decision; 5-bit wraparound is intentional and the
  // extra accumulator bit keeps -8 x -8 representable.
  always_comb begin
    a_sum = a_q;
    unique case ({qr_q[0], q1_q})
      2'b01:   a_sum = a_q + mr_q;
      2'b10:   a_sum = a_q - mr_q;
      default: a_sum = a_q;
    endcase
  end

  // Arithmetic shift right of {A, Qr, q_1}; A's sign bit is replicated.
  always_comb begin
    a_sh  = {a_sum[4], a_sum[4:1]};
    qr_sh = {a_sum[0], qr_q[3:1]};
    q1_sh = qr_q[0];
  end

  // Terminal count: the step taken while cnt is 1 brings it to zero.
  assign last_step = (cnt_q == 3'd1);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    mr_d    = mr_q;
    qr_d    = qr_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    done_d  = done_q;

    if (bus.load) begin
      state_d = RUN;
      a_d     = 5'd0;
      mr_d    = {bus.M[3], bus.M};
      qr_d    = bus.Q;
      q1_d    = 1'b0;
      cnt_d   = 3'd4;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          a_d   = a_sh;
          qr_d  = qr_sh;
          q1_d  = q1_sh;
          cnt_d = cnt_q - 3'd1;
          if (last_step) begin
            // Product is taken from the post-shift values of this same edge.
            p_d     = {a_sh[3:0], qr_sh};
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= 5'd0;
      mr_q    <= 5'd0;
      qr_q    <= 4'd0;
      q1_q    <= 1'b0;
      cnt_q   <= 3'd0;
      p_q     <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      mr_q    <= mr_d;
      qr_q    <= qr_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  assign bus.P    = p_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_iiitb_r2_4bit_bm.sv
// Directed bench for the radix-2 Booth multiplier. Inputs change on the
// falling clock edge; outputs are sampled on the falling edge as well.
module tb_iiitb_r2_4bit_bm;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  iiitb_r2_4bit_bm_if bus ();

  iiitb_r2_4bit_bm dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
    $fatal(1, "watchdog");
  end

  // Present operands and pulse load for exactly one rising edge.
  task automatic pulse_load(input logic [3:0] m, input logic [3:0] q);
    @(negedge clock);
    bus.M    = m;
    bus.Q    = q;
    bus.load = 1'b1;
    @(negedge clock);
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    bus.load = 1'b0;
    bus.M    = 4'd0;
    bus.Q    = 4'd0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (bus.P !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_p: got %h required %h", bus.P, 8'h00);
    end
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: got %b required %b", bus.done, 1'b0);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic();
    pulse_load(4'b1010, 4'b1011);  // -6 x -5
    n_checks++;
    if (bus.done !== 1'b0 || bus.P !== 8'h00) begin
      n_fail++;
      $display("FAIL basic_after_load: got P=%h done=%b required P=00 done=0", bus.P, bus.done);
    end
    for (int s = 1; s <= 3; s++) begin
      @(negedge clock);
      n_checks++;
      if (bus.done !== 1'b0 || bus.P !== 8'h00) begin
        n_fail++;
        $display("FAIL basic_step%0d: got P=%h done=%b required P=00 done=0", s, bus.P, bus.done);
      end
    end
    @(negedge clock);
    n_checks++;
    if (bus.done !== 1'b1 || bus.P !== 8'h1E) begin
      n_fail++;
      $display("FAIL basic_result: got P=%h done=%b required P=1e done=1", bus.P, bus.done);
    end
    // Operand changes while idle must not disturb the held result.
    bus.M = 4'd7;
    bus.Q = 4'd7;
    repeat (3) @(negedge clock);
    n_checks++;
    if (bus.done !== 1'b1 || bus.P !== 8'h1E) begin
      n_fail++;
      $display("FAIL basic_idle_hold: got P=%h done=%b required P=1e done=1", bus.P, bus.done);
    end
  endtask

  task automatic test_corners();
    logic [3:0] vm [4];
    logic [3:0] vq [4];
    logic [7:0] vp [4];
    vm[0] = 4'd7;    vq[0] = 4'd7;    vp[0] = 8'h31;
    vm[1] = 4'b1000; vq[1] = 4'b1000; vp[1] = 8'h40;
    vm[2] = 4'b1000; vq[2] = 4'd7;    vp[2] = 8'hC8;
    vm[3] = 4'd0;    vq[3] = 4'b1111; vp[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      pulse_load(vm[i], vq[i]);
      // Operands moving during the run must be ignored.
      bus.M = ~vm[i];
      bus.Q = ~vq[i];
      repeat (4) @(negedge clock);
      n_checks++;
      if (bus.done !== 1'b1 || bus.P !== vp[i]) begin
        n_fail++;
        $display("FAIL corner%0d: got P=%h done=%b required P=%h done=1", i, bus.P, bus.done, vp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    pulse_load(4'b1010, 4'b1011);
    repeat (4) @(negedge clock);
    n_checks++;
    if (bus.done !== 1'b1 || bus.P !== 8'h1E) begin
      n_fail++;
      $display("FAIL b2b_first: got P=%h done=%b required P=1e done=1", bus.P, bus.done);
    end
    // Second load on edge L+5, straight after the first result.
    bus.M    = 4'd3;
    bus.Q    = 4'b1110;
    bus.load = 1'b1;
    @(negedge clock);
    bus.load = 1'b0;
    n_checks++;
    if (bus.done !== 1'b0 || bus.P !== 8'h1E) begin
      n_fail++;
      $display("FAIL b2b_done_drop: got P=%h done=%b required P=1e done=0", bus.P, bus.done);
    end
    repeat (4) @(negedge clock);
    n_checks++;
    if (bus.done !== 1'b1 || bus.P !== 8'hFA) begin
      n_fail++;
      $display("FAIL b2b_second: got P=%h done=%b required P=fa done=1", bus.P, bus.done);
    end
  endtask

  task automatic test_restart();
    pulse_load(4'd5, 4'd5);
    repeat (2) @(negedge clock);
    pulse_load(4'd2, 4'd3);
    repeat (3) @(negedge clock);
    n_checks++;
    if (bus.done !== 1'b0 || bus.P !== 8'hFA) begin
      n_fail++;
      $display("FAIL restart_pending: got P=%h done=%b required P=fa done=0", bus.P, bus.done);
    end
    @(negedge clock);
    n_checks++;
    if (bus.done !== 1'b1 || bus.P !== 8'h06) begin
      n_fail++;
      $display("FAIL restart_result: got P=%h done=%b required P=06 done=1", bus.P, bus.done);
    end
  endtask

  task automatic test_load_held();
    // load high for three edges; stepping begins on the first low edge.
    @(negedge clock);
    bus.M    = 4'b1101;  // -3
    bus.Q    = 4'd4;
    bus.load = 1'b1;
    repeat (3) @(negedge clock);
    bus.load = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL held_early: got done=%b required done=0", bus.done);
    end
    @(negedge clock);
    n_checks++;
    if (bus.done !== 1'b1 || bus.P !== 8'hF4) begin
      n_fail++;
      $display("FAIL held_result: got P=%h done=%b required P=f4 done=1", bus.P, bus.done);
    end
  endtask

  task automatic test_async_reset();
    pulse_load(4'd7, 4'd6);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.P !== 8'h00 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got P=%h done=%b required P=00 done=0", bus.P, bus.done);
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);
    n_checks++;
    if (bus.P !== 8'h00 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_result: got P=%h done=%b required P=00 done=0", bus.P, bus.done);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_p;
    for (int mi = -8; mi < 8; mi++) begin
      for (int qi = -8; qi < 8; qi++) begin
        exp_p = 8'(mi * qi);
        pulse_load(4'(mi), 4'(qi));
        repeat (4) @(negedge clock);
        n_checks++;
        if (bus.done !== 1'b1 || bus.P !== exp_p) begin
          n_fail++;
          $display("FAIL sweep %0d*%0d: got P=%h done=%b required P=%h done=1", mi, qi, bus.P, bus.done, exp_p);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_restart();
    test_load_held();
    test_async_reset();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
